// File: rtl/ratio_streamer_pkg.sv
// Shared Raman definitions: frame header, ratio vector geometry and streamer state encoding.
package ratio_streamer_pkg;

    localparam int unsigned POINTS = 10;
    localparam int unsigned PT_W   = 12;
    localparam int unsigned VEC_W  = PT_W * POINTS;
    localparam int unsigned IDX_W  = $clog2(POINTS);

    localparam logic [7:0] RAMAN_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_FNUM = 3'd2,
        ST_DHI  = 3'd3,
        ST_DLO  = 3'd4,
        ST_CSUM = 3'd5
    } state_t;

    function automatic logic [7:0] hi_byte(input logic [PT_W-1:0] p);
        return {4'b0000, p[11:8]};
    endfunction

endpackage

// File: rtl/ratio_streamer_if.sv
// Ratio capture input plus framed byte stream output of the Raman ratio streamer.
interface ratio_streamer_if;
    import ratio_streamer_pkg::*;

    logic [VEC_W-1:0] ratio;
    logic             ready_ratio;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic [7:0]       frame_cnt;
    logic             overrun;

    modport master (
        input  ratio, ready_ratio, tx_ready,
        output tx_data, tx_valid, busy, frame_cnt, overrun
    );

    modport slave (
        output ratio, ready_ratio, tx_ready,
        input  tx_data, tx_valid, busy, frame_cnt, overrun
    );

endinterface

// File: rtl/ratio_streamer_byte_tx_reg.sv
// Output holding register for one byte plus its valid flag (valid/ready source side).
module byte_tx_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid
);

    logic w_fire;
    logic w_take;

    assign w_fire = o_valid & i_ready;
    assign w_take = i_load & (~o_valid | i_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data  <= 8'h00;
            o_valid <= 1'b0;
        end else if (w_take) begin
            o_data  <= i_data;
            o_valid <= 1'b1;
        end else if (w_fire) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ratio_streamer.sv
// Captures a ratio vector and streams it as HEADER, frame number, hi/lo bytes per point, XOR checksum.
module ratio_streamer
    import ratio_streamer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    ratio_streamer_if.master  bus
);

    state_t            r_state;
    logic [PT_W-1:0]   r_shadow [POINTS];
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_csum;
    logic [7:0]        r_frame_cnt;
    logic              r_busy;
    logic              r_overrun;

    logic              w_xfer;
    logic              w_accept;
    logic              w_last;
    logic              w_load;
    logic [7:0]        w_din;
    logic [7:0]        w_tx_data;
    logic              w_tx_valid;
    logic [IDX_W-1:0]  w_idx_nxt;

    assign w_xfer    = w_tx_valid & bus.tx_ready;
    assign w_last    = (r_idx == IDX_W'(POINTS - 1));
    assign w_idx_nxt = r_idx + IDX_W'(1);
    // A new vector is taken when idle or exactly as the checksum byte leaves.
    assign w_accept  = bus.ready_ratio &
                       ((r_state == ST_IDLE) | ((r_state == ST_CSUM) & w_xfer));

    // Byte to present next; loaded into the holding register on the advancing edge.
    always_comb begin
        w_load = 1'b0;
        w_din  = 8'h00;
        case (r_state)
            ST_IDLE: begin
                w_load = w_accept;
                w_din  = RAMAN_HEADER;
            end
            ST_HDR: begin
                w_load = w_xfer;
                w_din  = r_frame_cnt;
            end
            ST_FNUM: begin
                w_load = w_xfer;
                w_din  = hi_byte(r_shadow[r_idx]);
            end
            ST_DHI: begin
                w_load = w_xfer;
                w_din  = r_shadow[r_idx][7:0];
            end
            ST_DLO: begin
                w_load = w_xfer;
                w_din  = w_last ? (r_csum ^ w_tx_data) : hi_byte(r_shadow[w_idx_nxt]);
            end
            ST_CSUM: begin
                w_load = w_accept;
                w_din  = RAMAN_HEADER;
            end
            default: ;
        endcase
    end

    byte_tx_reg u_tx (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_din),
        .i_ready (bus.tx_ready),
        .o_data  (w_tx_data),
        .o_valid (w_tx_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_csum      <= 8'h00;
            r_frame_cnt <= 8'h00;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < POINTS; i++) r_shadow[i] <= '0;
        end else begin
            if (bus.ready_ratio & ~w_accept) r_overrun <= 1'b1;
            if ((r_state == ST_CSUM) & w_xfer) r_frame_cnt <= r_frame_cnt + 8'd1;

            if (w_accept) begin
                for (int i = 0; i < POINTS; i++) r_shadow[i] <= bus.ratio[PT_W*i +: PT_W];
                r_idx   <= '0;
                r_csum  <= 8'h00;
                r_state <= ST_HDR;
                r_busy  <= 1'b1;
            end else if (w_xfer) begin
                case (r_state)
                    ST_HDR:  r_state <= ST_FNUM;
                    ST_FNUM: begin
                        r_csum  <= r_csum ^ w_tx_data;
                        r_state <= ST_DHI;
                    end
                    ST_DHI: begin
                        r_csum  <= r_csum ^ w_tx_data;
                        r_state <= ST_DLO;
                    end
                    ST_DLO: begin
                        r_csum <= r_csum ^ w_tx_data;
                        if (w_last) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_idx   <= w_idx_nxt;
                            r_state <= ST_DHI;
                        end
                    end
                    ST_CSUM: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.tx_data   = w_tx_data;
    assign bus.tx_valid  = w_tx_valid;
    assign bus.busy      = r_busy;
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_ratio_streamer.sv
// Randomised bench for ratio_streamer against a byte-queue frame model.
module tb_ratio_streamer;
    import ratio_streamer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ratio_streamer_if bus();

    ratio_streamer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of bytes still owed to the link, with end-of-frame marks.
    logic [7:0] exp_q[$];
    bit         last_q[$];
    logic [7:0] m_cnt;
    bit         m_ovr;
    bit         prev_stall;
    logic [7:0] prev_data;
    int         xfers;
    int         byte_pos;
    logic [7:0] last_fnum;
    logic [7:0] last_byte;
    bit         tog;

    task automatic push_frame(input logic [VEC_W-1:0] vec);
        logic [7:0]  cs;
        logic [11:0] p;
        logic [7:0]  b;
        exp_q.push_back(8'hA5); last_q.push_back(1'b0);
        exp_q.push_back(m_cnt); last_q.push_back(1'b0);
        cs = m_cnt;
        for (int i = 0; i < 10; i++) begin
            p = vec[12*i +: 12];
            b = {4'h0, p[11:8]};
            exp_q.push_back(b); last_q.push_back(1'b0); cs = cs ^ b;
            b = p[7:0];
            exp_q.push_back(b); last_q.push_back(1'b0); cs = cs ^ b;
        end
        exp_q.push_back(cs); last_q.push_back(1'b1);
    endtask

    task automatic model_clear();
        exp_q.delete();
        last_q.delete();
        m_cnt      = 8'h00;
        m_ovr      = 1'b0;
        prev_stall = 1'b0;
        byte_pos   = 0;
    endtask

    // One clock: compare at the falling edge, then advance the model with this cycle's inputs.
    task automatic cycle();
        bit mv;
        @(negedge clk);
        if (!rst) begin
            mv = (exp_q.size() != 0);
            check_eq("tx_valid",  32'(bus.tx_valid),  32'(mv));
            check_eq("busy",      32'(bus.busy),      32'(mv));
            check_eq("frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
            check_eq("overrun",   32'(bus.overrun),   32'(m_ovr));
            if (mv) check_eq("tx_data", 32'(bus.tx_data), 32'(exp_q[0]));
            if (prev_stall) check_eq("stall_hold", 32'(bus.tx_data), 32'(prev_data));
            prev_stall = mv && !bus.tx_ready;
            prev_data  = bus.tx_data;
            if (mv && bus.tx_ready) begin
                xfers++;
                last_byte = bus.tx_data;
                if (byte_pos == 1) last_fnum = bus.tx_data;
                if (last_q[0]) begin
                    m_cnt    = m_cnt + 8'd1;
                    byte_pos = 0;
                end else begin
                    byte_pos++;
                end
                void'(exp_q.pop_front());
                void'(last_q.pop_front());
            end
            if (bus.ready_ratio) begin
                if (exp_q.size() == 0) push_frame(bus.ratio);
                else m_ovr = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input int mode);
        case (mode)
            0: bus.tx_ready = 1'b1;
            1: begin bus.tx_ready = tog; tog = ~tog; end
            default: bus.tx_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic rand_vec();
        logic [VEC_W-1:0] v;
        for (int i = 0; i < 10; i++) v[12*i +: 12] = 12'($urandom);
        bus.ratio = v;
    endtask

    task automatic strobe();
        bus.ready_ratio = 1'b1;
        cycle();
        bus.ready_ratio = 1'b0;
    endtask

    task automatic drain(input int mode, output int ncyc);
        ncyc = 0;
        while (exp_q.size() != 0 && ncyc < 2000) begin
            set_ready(mode);
            cycle();
            ncyc++;
        end
        check_eq("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_remaining(input int n);
        int guard;
        guard = 0;
        while (exp_q.size() != n && guard < 200) begin
            cycle();
            guard++;
        end
        check_eq("wait_bound", 32'(exp_q.size()), 32'(n));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.ready_ratio = 1'b0;
        #1;
        check_eq("rst_valid", 32'(bus.tx_valid),  32'd0);
        check_eq("rst_busy",  32'(bus.busy),      32'd0);
        check_eq("rst_cnt",   32'(bus.frame_cnt), 32'd0);
        check_eq("rst_ovr",   32'(bus.overrun),   32'd0);
        check_eq("rst_data",  32'(bus.tx_data),   32'd0);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int ncyc;
        int x0;
        logic [7:0]       cnt0;
        logic [VEC_W-1:0] v;

        bus.ratio = '0;
        bus.ready_ratio = 1'b0;
        bus.tx_ready = 1'b0;
        xfers = 0;
        tog = 1'b1;
        last_fnum = 8'h00;
        last_byte = 8'h00;
        apply_reset();

        // All points 12'h123, link always ready: 23 back-to-back bytes.
        bus.tx_ready = 1'b1;
        repeat (9) cycle();
        for (int i = 0; i < 10; i++) v[12*i +: 12] = 12'h123;
        bus.ratio = v;
        x0 = xfers;
        strobe();
        drain(0, ncyc);
        check_eq("t2_cycles", 32'(ncyc), 32'd23);
        check_eq("t2_bytes", 32'(xfers - x0), 32'd23);
        check_eq("t2_csum", 32'(last_byte), 32'h00);
        check_eq("t2_cnt", 32'(bus.frame_cnt), 32'd1);
        check_eq("t2_ovr", 32'(bus.overrun), 32'd0);

        // Point i = 12'h100+i, link ready toggling every cycle.
        for (int i = 0; i < 10; i++) v[12*i +: 12] = 12'h100 + 12'(i);
        bus.ratio = v;
        tog = 1'b0;
        bus.tx_ready = 1'b1;
        strobe();
        drain(1, ncyc);
        check_eq("t3_csum", 32'(last_byte), 32'h00 ^ 32'h01 ^ 32'h01);
        check_eq("t3_cnt", 32'(bus.frame_cnt), 32'd2);

        // New vector coincident with the checksum transfer.
        bus.tx_ready = 1'b1;
        rand_vec();
        strobe();
        wait_remaining(1);
        rand_vec();
        strobe();
        check_eq("t5_hdr", 32'(bus.tx_data), 32'hA5);
        check_eq("t5_valid", 32'(bus.tx_valid), 32'd1);
        drain(0, ncyc);
        check_eq("t5_ovr", 32'(bus.overrun), 32'd0);
        check_eq("t5_cnt", 32'(bus.frame_cnt), 32'd4);

        // Second vector while byte 7 is on the link: dropped, overrun sticks.
        rand_vec();
        cnt0 = bus.frame_cnt;
        strobe();
        wait_remaining(17);
        rand_vec();
        strobe();
        drain(2, ncyc);
        check_eq("t4_ovr", 32'(bus.overrun), 32'd1);
        check_eq("t4_cnt", 32'(bus.frame_cnt), 32'(cnt0 + 8'd1));
        repeat (3) cycle();
        check_eq("t4_ovr_sticky", 32'(bus.overrun), 32'd1);

        // Reset after five bytes of a frame.
        bus.tx_ready = 1'b1;
        rand_vec();
        strobe();
        repeat (5) cycle();
        apply_reset();
        repeat (2) cycle();
        rand_vec();
        strobe();
        check_eq("t1_hdr", 32'(bus.tx_data), 32'hA5);
        drain(0, ncyc);
        check_eq("t1_cnt", 32'(bus.frame_cnt), 32'd1);

        // 257 back-to-back frames from reset: counter wraps, frame 257 carries 00.
        apply_reset();
        bus.tx_ready = 1'b1;
        rand_vec();
        strobe();
        for (int f = 0; f < 256; f++) begin
            wait_remaining(1);
            rand_vec();
            strobe();
        end
        drain(0, ncyc);
        check_eq("t6_fnum257", 32'(last_fnum), 32'h00);
        check_eq("t6_cnt", 32'(bus.frame_cnt), 32'h01);
        check_eq("t6_ovr", 32'(bus.overrun), 32'd0);

        // Random strobes and random link back-pressure.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            set_ready(2);
            if ($urandom_range(0, 29) == 0) begin
                rand_vec();
                bus.ready_ratio = 1'b1;
            end
            cycle();
            bus.ready_ratio = 1'b0;
        end
        drain(2, ncyc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
